// File: rtl/spike_event_packetizer.sv
// Captures a per-timestep spike vector and streams one packet per set bit,
// lowest neuron index first, tagged with the timestep it was captured in.
module spike_event_packetizer #(
  parameter int N_NEURONS = 256,
  parameter int IDX_W     = 8,
  parameter int TICK_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_NEURONS-1:0] spike_vec_i,
  input  logic                 spike_valid_i,
  output logic                 pkt_valid_o,
  input  logic                 pkt_ready_i,
  output logic [IDX_W-1:0]     pkt_idx_o,
  output logic [TICK_W-1:0]    pkt_tick_o,
  output logic                 pkt_last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o,
  input  logic                 clear_overflow_i,
  output logic [1:0]           state_o
);

  // Stream handshake: a packet transfers on any rising clk edge where
  // pkt_valid_o & pkt_ready_i; while valid is high and ready is low the
  // payload holds, and valid only falls after a transfer (or on reset).

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [N_NEURONS-1:0] snap;
  logic [TICK_W-1:0]    tick;
  logic [TICK_W-1:0]    tag;
  logic                 overflow;

  logic [IDX_W-1:0]     low_idx;
  logic [N_NEURONS-1:0] snap_rest;
  logic                 one_left;
  logic                 handshake;

  always_comb begin
    low_idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (snap[i]) low_idx = IDX_W'(i);
    end
  end

  // snap with its lowest set bit cleared; zero means exactly one bit remains.
  assign snap_rest = snap & (snap - {{(N_NEURONS-1){1'b0}}, 1'b1});
  assign one_left  = (snap != '0) && (snap_rest == '0);
  assign handshake = (state == SCAN) && pkt_ready_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      snap     <= '0;
      tick     <= '0;
      tag      <= '0;
      overflow <= 1'b0;
    end else begin
      if (spike_valid_i && (state != IDLE)) overflow <= 1'b1;
      else if (clear_overflow_i)            overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (spike_valid_i) begin
            snap <= spike_vec_i;
            tick <= tick + 1'b1;
            // The visible tag only moves when packets follow, so it holds
            // across zero-spike timesteps.
            if (spike_vec_i != '0) begin
              tag   <= tick;
              state <= SCAN;
            end else begin
              state <= DONE;
            end
          end
        end
        SCAN: begin
          if (handshake) begin
            snap <= snap_rest;
            if (one_left) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pkt_valid_o = (state == SCAN);
  assign pkt_idx_o   = (state == SCAN) ? low_idx : '0;
  assign pkt_last_o  = (state == SCAN) && one_left;
  assign pkt_tick_o  = tag;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign overflow_o  = overflow;
  assign state_o     = state;

endmodule

// File: tb/tb_spike_event_packetizer.sv
// Directed bench for spike_event_packetizer: inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_spike_event_packetizer;

  localparam int N = 256;
  localparam int IW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  spike_vec = '0;
  logic          spike_valid = 1'b0;
  logic          pkt_valid;
  logic          pkt_ready = 1'b0;
  logic [IW-1:0] pkt_idx;
  logic [TW-1:0] pkt_tick;
  logic          pkt_last;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          clear_overflow = 1'b0;
  logic [1:0]    state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spike_event_packetizer #(.N_NEURONS(N), .IDX_W(IW), .TICK_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .spike_vec_i(spike_vec), .spike_valid_i(spike_valid),
    .pkt_valid_o(pkt_valid), .pkt_ready_i(pkt_ready),
    .pkt_idx_o(pkt_idx), .pkt_tick_o(pkt_tick), .pkt_last_o(pkt_last),
    .busy_o(busy), .done_o(done), .overflow_o(overflow),
    .clear_overflow_i(clear_overflow), .state_o(state)
  );

  task automatic step();
    @(negedge clk);
  endtask

  // Pulse a strobe for exactly one rising edge.
  task automatic strobe(input logic [N-1:0] v);
    spike_vec = v;
    spike_valid = 1'b1;
    step();
    spike_valid = 1'b0;
    spike_vec = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    checks++;
    if ({pkt_valid, pkt_idx, pkt_tick, pkt_last, busy, done, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b idx=%0d tick=%0d last=%0b busy=%0b done=%0b ovf=%0b, want all 0",
               pkt_valid, pkt_idx, pkt_tick, pkt_last, busy, done, overflow);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_three_spikes();
    logic [N-1:0] v;
    int exp_idx[3];
    exp_idx = '{3, 17, 255};
    v = '0; v[3] = 1'b1; v[17] = 1'b1; v[255] = 1'b1;
    pkt_ready = 1'b1;
    strobe(v);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pkt_valid !== 1'b1 || pkt_idx !== IW'(exp_idx[k]) || pkt_tick !== 16'd0 ||
          pkt_last !== (k == 2) || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL three_pkt%0d: got v=%0b idx=%0d tick=%0d last=%0b busy=%0b done=%0b, want v=1 idx=%0d tick=0 last=%0b busy=1 done=0",
                 k, pkt_valid, pkt_idx, pkt_tick, pkt_last, busy, done, exp_idx[k], (k == 2));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || pkt_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL three_done: got done=%0b v=%0b busy=%0b, want done=1 v=0 busy=1", done, pkt_valid, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL three_idle: got done=%0b busy=%0b, want 0 0", done, busy);
    end
    pkt_ready = 1'b0;
  endtask

  task automatic test_all_ones_stall();
    int e = 0;
    int errs = 0;
    int cyc = 0;
    logic rdy = 1'b1;
    strobe({N{1'b1}});
    while (e < 256 && cyc < 1000) begin
      if (pkt_valid !== 1'b1 || pkt_idx !== IW'(e) || pkt_tick !== 16'd1 || pkt_last !== (e == 255)) begin
        if (errs < 4)
          $display("FAIL all_ones_pkt: got v=%0b idx=%0d tick=%0d last=%0b, want v=1 idx=%0d tick=1 last=%0b",
                   pkt_valid, pkt_idx, pkt_tick, pkt_last, e, (e == 255));
        errs++;
      end
      pkt_ready = rdy;
      step();
      if (rdy) e++;
      rdy = ~rdy;
      cyc++;
    end
    pkt_ready = 1'b0;
    checks++;
    if (errs != 0 || e != 256) begin
      failures++;
      $display("FAIL all_ones_sequence: got %0d bad samples, %0d packets, want 0 bad and 256 packets", errs, e);
    end
    checks++;
    if (done !== 1'b1 || pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL all_ones_done: got done=%0b v=%0b, want done=1 v=0", done, pkt_valid);
    end
    step();
  endtask

  task automatic test_zero_vector();
    strobe('0);
    checks++;
    if (pkt_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || pkt_tick !== 16'd1) begin
      failures++;
      $display("FAIL zero_done: got v=%0b done=%0b busy=%0b tick=%0d, want v=0 done=1 busy=1 tick=1",
               pkt_valid, done, busy, pkt_tick);
    end
    step();
    checks++;
    if (pkt_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_idle: got v=%0b done=%0b busy=%0b, want 0 0 0", pkt_valid, done, busy);
    end
  endtask

  task automatic test_overflow();
    logic [N-1:0] v;
    v = '0; v[5] = 1'b1;
    strobe(v);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_idx !== 8'd5 || pkt_tick !== 16'd3 || pkt_last !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_first: got v=%0b idx=%0d tick=%0d last=%0b ovf=%0b, want v=1 idx=5 tick=3 last=1 ovf=0",
               pkt_valid, pkt_idx, pkt_tick, pkt_last, overflow);
    end
    v = '0; v[9] = 1'b1;
    strobe(v);
    step();
    checks++;
    if (overflow !== 1'b1 || pkt_valid !== 1'b1 || pkt_idx !== 8'd5 || pkt_tick !== 16'd3 || pkt_last !== 1'b1) begin
      failures++;
      $display("FAIL ovf_dropped: got ovf=%0b v=%0b idx=%0d tick=%0d last=%0b, want ovf=1 v=1 idx=5 tick=3 last=1",
               overflow, pkt_valid, pkt_idx, pkt_tick, pkt_last);
    end
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got %0b, want 0", overflow);
    end
    clear_overflow = 1'b1;
    strobe(v);
    clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b1 || pkt_idx !== 8'd5) begin
      failures++;
      $display("FAIL ovf_set_wins: got ovf=%0b idx=%0d, want ovf=1 idx=5", overflow, pkt_idx);
    end
    pkt_ready = 1'b1;
    step();
    pkt_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_drain: got done=%0b ovf=%0b, want done=1 ovf=1", done, overflow);
    end
    step();
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
  endtask

  task automatic test_tick_wrap();
    logic [N-1:0] v;
    force dut.tick = 16'hFFFF;
    step();
    release dut.tick;
    v = '0; v[0] = 1'b1;
    pkt_ready = 1'b1;
    strobe(v);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_tick !== 16'hFFFF || pkt_idx !== 8'd0 || pkt_last !== 1'b1) begin
      failures++;
      $display("FAIL wrap_max: got v=%0b tick=%h idx=%0d last=%0b, want v=1 tick=ffff idx=0 last=1",
               pkt_valid, pkt_tick, pkt_idx, pkt_last);
    end
    step(); step();
    v = '0; v[7] = 1'b1;
    strobe(v);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_tick !== 16'h0000 || pkt_idx !== 8'd7) begin
      failures++;
      $display("FAIL wrap_zero: got v=%0b tick=%h idx=%0d, want v=1 tick=0000 idx=7", pkt_valid, pkt_tick, pkt_idx);
    end
    step(); step();
    pkt_ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    logic [N-1:0] v;
    v = '0; v[1] = 1'b1; v[2] = 1'b1;
    strobe(v);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (pkt_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pkt_tick !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_scan: got v=%0b busy=%0b done=%0b tick=%0d, want 0 0 0 0", pkt_valid, busy, done, pkt_tick);
    end
    step();
    reset_n = 1'b1;
    step();
    v = '0; v[4] = 1'b1;
    strobe(v);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_idx !== 8'd4 || pkt_tick !== 16'd0 || pkt_last !== 1'b1) begin
      failures++;
      $display("FAIL reset_fresh: got v=%0b idx=%0d tick=%0d last=%0b, want v=1 idx=4 tick=0 last=1",
               pkt_valid, pkt_idx, pkt_tick, pkt_last);
    end
  endtask

  initial begin
    test_reset();
    test_three_spikes();
    test_all_ones_stall();
    test_zero_vector();
    test_overflow();
    test_tick_wrap();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
